ramarb: RTL and testbench

Two-port RAM arbiter for the DE2-115 memctrl-32 experiments. It shares the single memory-controller port (stb/we/addr/dout/din/ack, 27-bit word address, 32-bit data) between a read-only instruction client and a read/write data client. Simultaneous requests are resolved round-robin. A grant is held until the controller acknowledges, or until a watchdog aborts the transfer. It sits between the CPU-side clients (or two ramtest instances) and memctrl.

---
 rtl/ramarb.sv | 116 +++++++++++
 tb/tb_ramarb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ramarb.sv
// ramarb: round-robin arbiter sharing one memctrl port between a read-only
// instruction client and a read/write data client, with a grant watchdog.
module ramarb #(
    parameter int TIMEOUT_BITS = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inst_stb_i,
    input  logic [26:0] inst_addr_i,
    output logic [31:0] inst_dout_o,
    output logic        inst_ack_o,
    input  logic        data_stb_i,
    input  logic        data_we_i,
    input  logic [26:0] data_addr_i,
    input  logic [31:0] data_din_i,
    output logic [31:0] data_dout_o,
    output logic        data_ack_o,
    output logic        ram_stb_o,
    output logic        ram_we_o,
    output logic [26:0] ram_addr_o,
    output logic [31:0] ram_dout_o,
    input  logic [31:0] ram_din_i,
    input  logic        ram_ack_i,
    output logic        timeout_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    last_q;       // 1'b0 = inst served last, 1'b1 = data
    logic [TIMEOUT_BITS-1:0] wd_q;
    logic                    timeout_err_q;

    logic wd_max_s;
    logic expire_s;

    assign wd_max_s      = (wd_q == {TIMEOUT_BITS{1'b1}});
    // A coincident ram_ack beats the watchdog, so expiry needs ack low.
    assign expire_s      = wd_max_s && !ram_ack_i;
    assign timeout_err_o = timeout_err_q;

    // Arbitration FSM, last-served tracking, watchdog and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            wd_q          <= {TIMEOUT_BITS{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wd_q <= {TIMEOUT_BITS{1'b0}};
                    if (inst_stb_i && (!data_stb_i || last_q)) begin
                        state_q <= GNT_I;
                    end else if (data_stb_i) begin
                        state_q <= GNT_D;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GNT_I, GNT_D: begin
                    if (ram_ack_i || wd_max_s) begin
                        state_q <= IDLE;
                        last_q  <= (state_q == GNT_D);
                        wd_q    <= {TIMEOUT_BITS{1'b0}};
                        if (!ram_ack_i) begin
                            timeout_err_q <= 1'b1;
                        end
                    end else begin
                        wd_q <= wd_q + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wd_q    <= {TIMEOUT_BITS{1'b0}};
                end
            endcase
        end
    end

    // Memory-side mux and client completion routing for the granted port.
    always_comb begin
        ram_stb_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = 27'd0;
        ram_dout_o  = 32'd0;
        inst_ack_o  = 1'b0;
        data_ack_o  = 1'b0;
        inst_dout_o = 32'd0;
        data_dout_o = 32'd0;
        case (state_q)
            GNT_I: begin
                ram_stb_o   = 1'b1;
                ram_addr_o  = inst_addr_i;
                inst_ack_o  = ram_ack_i || wd_max_s;
                inst_dout_o = expire_s ? 32'd0 : ram_din_i;
            end
            GNT_D: begin
                ram_stb_o   = 1'b1;
                ram_we_o    = data_we_i;
                ram_addr_o  = data_addr_i;
                ram_dout_o  = data_din_i;
                data_ack_o  = ram_ack_i || wd_max_s;
                data_dout_o = expire_s ? 32'd0 : ram_din_i;
            end
            default: begin
                ram_stb_o = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ramarb.sv
// Randomized bench for ramarb: a transaction-level model (owner, grant age,
// last-served) predicts every output each cycle.
module tb_ramarb;
    localparam int TB    = 4;
    localparam int LIMIT = (1 << TB) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_stb, data_stb, data_we, ram_ack;
    logic [26:0] inst_addr, data_addr;
    logic [31:0] data_din, ram_din;
    logic [31:0] inst_dout, data_dout, ram_dout;
    logic        inst_ack, data_ack, ram_stb, ram_we, timeout_err;
    logic [26:0] ram_addr;

    int errors = 0;
    int checks = 0;

    // model: owner 0 = nobody, 1 = inst, 2 = data; last 0 = inst, 1 = data
    int owner, age, last;
    bit terr;

    // stimulus knobs
    bit auto_cli;
    bit drop_en;
    int req_prob;
    int ack_mode;   // 0 random, 1 never, 2 at fixed grant age, 3 always
    int ack_lat;

    always #5 clk = ~clk;

    ramarb #(.TIMEOUT_BITS(TB)) dut (
        .clk_i(clk), .rst_i(rst),
        .inst_stb_i(inst_stb), .inst_addr_i(inst_addr),
        .inst_dout_o(inst_dout), .inst_ack_o(inst_ack),
        .data_stb_i(data_stb), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_din_i(data_din), .data_dout_o(data_dout), .data_ack_o(data_ack),
        .ram_stb_o(ram_stb), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_dout_o(ram_dout), .ram_din_i(ram_din), .ram_ack_i(ram_ack),
        .timeout_err_o(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0;
        age   = 0;
        last  = 1;
        terr  = 1'b0;
    endtask

    task automatic drive_inputs();
        if (auto_cli) begin
            if (!inst_stb && ($urandom_range(99) < req_prob)) begin
                inst_stb  = 1'b1;
                inst_addr = 27'($urandom());
            end
            if (!data_stb && ($urandom_range(99) < req_prob)) begin
                data_stb  = 1'b1;
                data_we   = 1'($urandom_range(1));
                data_addr = 27'($urandom());
                data_din  = $urandom();
            end
            if (drop_en && inst_stb && ($urandom_range(60) == 0)) inst_stb = 1'b0;
            if (drop_en && data_stb && ($urandom_range(60) == 0)) data_stb = 1'b0;
        end
        ram_din = $urandom();
        case (ack_mode)
            0:       ram_ack = ($urandom_range(3) == 0);
            2:       ram_ack = (owner != 0) && (age == ack_lat);
            3:       ram_ack = 1'b1;
            default: ram_ack = 1'b0;
        endcase
    endtask

    // One clock: drive at negedge, compare, advance the model at posedge.
    task automatic step();
        bit fin, to, e_iack, e_dack;
        logic [31:0] e_idout, e_ddout;
        drive_inputs();
        #1;
        fin     = (owner != 0) && (ram_ack || age == LIMIT);
        to      = (owner != 0) && !ram_ack && (age == LIMIT);
        e_iack  = (owner == 1) && fin;
        e_dack  = (owner == 2) && fin;
        e_idout = (owner == 1 && !to) ? ram_din : 32'd0;
        e_ddout = (owner == 2 && !to) ? ram_din : 32'd0;
        check("ram_stb", 64'(ram_stb), 64'(owner != 0));
        check("ram_we", 64'(ram_we), 64'((owner == 2) ? data_we : 1'b0));
        check("ram_addr", 64'(ram_addr),
              64'((owner == 1) ? inst_addr : (owner == 2) ? data_addr : 27'd0));
        check("ram_dout", 64'(ram_dout), 64'((owner == 2) ? data_din : 32'd0));
        check("inst_ack", 64'(inst_ack), 64'(e_iack));
        check("data_ack", 64'(data_ack), 64'(e_dack));
        check("inst_dout", 64'(inst_dout), 64'(e_idout));
        check("data_dout", 64'(data_dout), 64'(e_ddout));
        check("timeout_err", 64'(timeout_err), 64'(terr));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (owner == 0) begin
            age = 0;
            if (inst_stb && data_stb) owner = (last == 1) ? 1 : 2;
            else if (inst_stb)        owner = 1;
            else if (data_stb)        owner = 2;
            else                      owner = 0;
        end else if (fin) begin
            last  = (owner == 2) ? 1 : 0;
            owner = 0;
            age   = 0;
            if (to) terr = 1'b1;
        end else begin
            age++;
        end
        @(negedge clk);
        if (e_iack) inst_stb = 1'b0;
        if (e_dack) data_stb = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inst_stb = 1'b0; data_stb = 1'b0; data_we = 1'b0; ram_ack = 1'b0;
        inst_addr = 27'd0; data_addr = 27'd0; data_din = 32'd0; ram_din = 32'd0;
        auto_cli = 1'b0; drop_en = 1'b0; req_prob = 0; ack_mode = 1; ack_lat = 0;
        @(negedge clk);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        step();

        // both clients request from cycle 1, memctrl acks 3 cycles in
        rst = 1'b0;
        inst_stb = 1'b1; inst_addr = 27'h0AAAAAA;
        data_stb = 1'b1; data_addr = 27'h1555555; data_we = 1'b0;
        ack_mode = 2; ack_lat = 3; auto_cli = 1'b1; req_prob = 100;
        repeat (26) step();
        auto_cli = 1'b0;
        repeat (12) step();

        // data write, then instruction read of the same word
        data_stb = 1'b1; data_we = 1'b1; data_addr = 27'h0123456; data_din = 32'hDEADBEEF;
        repeat (6) step();
        inst_stb = 1'b1; inst_addr = 27'h0123456;
        repeat (6) step();

        // instruction read while the idle data port holds we=1
        data_we = 1'b1; inst_stb = 1'b1; inst_addr = 27'h7000001;
        repeat (6) step();

        // watchdog expiry, then an ack landing exactly on the last grant cycle
        ack_mode = 1; inst_stb = 1'b1; inst_addr = 27'h0000042;
        repeat (LIMIT + 5) step();
        ack_mode = 2; ack_lat = LIMIT; data_stb = 1'b1; data_we = 1'b0;
        repeat (LIMIT + 5) step();

        // reset mid-grant with a coincident ram_ack
        ack_mode = 1; data_stb = 1'b1; data_addr = 27'h0000777;
        repeat (3) step();
        rst = 1'b1; ack_mode = 3;
        step();
        rst = 1'b0; ack_mode = 2; ack_lat = 2;
        inst_stb = 1'b1; inst_addr = 27'h0000111;
        data_stb = 1'b1; data_addr = 27'h0000222;
        repeat (10) step();

        // randomized traffic with protocol violations and occasional resets
        auto_cli = 1'b1; drop_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                ack_mode = $urandom_range(2);
                ack_lat  = $urandom_range(LIMIT);
                req_prob = $urandom_range(100);
            end
            rst = ($urandom_range(299) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
